ysyx_22050612_mem_arb: RTL and testbench
========================================

Name: ysyx_22050612_mem_arb

Overview:
- Two-master, one-slave arbiter/sequencer for the single data-memory port.
- Masters: IFU (instruction fetch, read-only) and LSU (loads/stores with byte mask).
- One transaction outstanding at a time; the response is routed back to the owning master.
- LSU has fixed priority; a wait counter forces an IFU grant after MAX_WAIT cycles so fetch is never starved.

Parameters:
- MAX_WAIT, 4: IFU wait cycles (pending and not granted) after which IFU wins arbitration. Legal range 1..255.
- CNT_W, 8: width of the IFU wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- if_req_valid  in  1  IFU read request.
- if_addr  in  64  IFU read address.
- if_req_ready  out  1  IFU request accepted this cycle.
- if_resp_valid  out  1  IFU read data valid, one-cycle pulse.
- if_rdata  out  64  IFU read data.
- ls_req_valid  in  1  LSU request.
- ls_addr  in  64  LSU address.
- ls_wen  in  1  1 = write, 0 = read.
- ls_wdata  in  64  LSU write data, lane-aligned.
- ls_wmask  in  8  LSU byte write mask.
- ls_req_ready  out  1  LSU request accepted this cycle.
- ls_resp_valid  out  1  LSU read data or write ack, one-cycle pulse.
- ls_rdata  out  64  LSU read data.
- mem_req_valid  out  1  request to memory.
- mem_addr  out  64  request address.
- mem_wen  out  1  request write enable.
- mem_wdata  out  64  request write data.
- mem_wmask  out  8  request byte mask.
- mem_req_ready  in  1  memory accepts the request.
- mem_resp_valid  in  1  memory response, one-cycle pulse.
- mem_rdata  in  64  memory read data.
- busy  out  1  transaction in flight (state is not IDLE).
- err_resp  out  1  sticky: mem_resp_valid arrived outside WAIT.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state returns to IDLE; owner, wait counter and err_resp clear.
  - All outputs go to 0, including the data buses.
  - Reset takes effect in any state, including mid-transaction; the in-flight request is abandoned.
- State machine: IDLE -> REQ -> WAIT -> IDLE.
- IDLE, arbitration is combinational in this cycle:
  - IFU wins if if_req_valid && (wait_cnt >= MAX_WAIT || !ls_req_valid).
  - Otherwise LSU wins if ls_req_valid.
  - The winner's *_req_ready is 1 for exactly this cycle.
  - Winner's address/wen/wdata/wmask are captured into registers; owner is latched; state goes to REQ.
  - An IFU capture forces wen=0 and wmask=0.
  - At most one ready is high per cycle.
- REQ:
  - mem_req_valid=1, mem_* driven from the captured registers and stable while waiting.
  - On mem_req_ready=1, go to WAIT.
- WAIT:
  - When mem_resp_valid=1, pulse the owner's *_resp_valid for that same cycle, with *_rdata = mem_rdata (combinational pass-through).
  - The non-owner's resp_valid stays 0.
  - Go to IDLE; a new grant is possible in the very next cycle.
  - Writes complete the same way; ls_rdata is don't-care on a write ack.
- Minimum latency: accept at cycle N; mem_req_valid at N+1; with mem_req_ready=1 at N+1 and a response at N+2, resp_valid is at N+2.
- Wait counter:
  - Increments (saturating at 2^CNT_W-1) each cycle if_req_valid=1 and IFU is not accepted.
  - Clears when IFU is accepted or when if_req_valid=0.
- mem_resp_valid in IDLE or REQ:
  - Ignored: no resp_valid is generated.
  - Sets err_resp, which holds until reset.
- Masters must hold request fields stable while valid && !ready. Dropping valid before ready is tolerated; no transaction is issued.
- Outside REQ, mem_req_valid=0 and mem_* hold their last captured values; only mem_req_valid is meaningful.

Test Plan:
- IFU only: if_req_valid=1, if_addr=0x8000_0000; mem ready at once, response 1 cycle later with rdata=0x0000_0013_0000_0093 -> if_req_ready high at cycle 0, mem_req_valid at cycle 1 with addr 0x8000_0000 and wen=0, if_resp_valid at cycle 2 with that rdata, ls_resp_valid=0 throughout.
- Contention: both masters valid every cycle; LSU store addr=0x8000_1004, wdata=0x1122_3344_0000_0000, wmask=0xF0 -> LSU granted first; mem_wmask=0xF0 and mem_wen=1; ls_resp_valid pulses on the write ack.
- Starvation, MAX_WAIT=4: LSU valid continuously, IFU valid continuously -> IFU granted no later than its 5th IDLE arbitration; counter returns to 0 after the grant.
- Backpressure: mem_req_ready held 0 for 6 cycles -> mem_req_valid and mem_addr stable for all 6 cycles; no second grant; busy=1.
- Reset mid-WAIT: drop rst_n for 1 cycle, then the stale mem_resp_valid arrives -> all outputs 0 after the reset edge; no resp_valid pulse; err_resp=1.
- Spurious response in IDLE -> err_resp=1 and stays 1 through 10 further normal transactions until reset.

Source files
------------

// File: rtl/ysyx_22050612_mem_arb_if.sv
// Purpose: bundle of the IFU, LSU and data-memory handshake signals around the arbiter.
// Latency: wiring only; no state.
// Backpressure: valid/ready on each request channel; responses are single-cycle pulses.
interface ysyx_22050612_mem_arb_if;
  // IFU read-only request channel
  logic        if_req_valid;
  logic [63:0] if_addr;
  logic        if_req_ready;
  logic        if_resp_valid;
  logic [63:0] if_rdata;

  // LSU load/store channel
  logic        ls_req_valid;
  logic [63:0] ls_addr;
  logic        ls_wen;
  logic [63:0] ls_wdata;
  logic [7:0]  ls_wmask;
  logic        ls_req_ready;
  logic        ls_resp_valid;
  logic [63:0] ls_rdata;

  // shared data-memory port
  logic        mem_req_valid;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [63:0] mem_rdata;

  // arbiter view: serves the two CPU masters and drives the memory port
  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_resp_valid, if_rdata,
    input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    output ls_req_ready, ls_resp_valid, ls_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  // environment view: the CPU masters plus the memory model
  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_resp_valid, if_rdata,
    output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    input  ls_req_ready, ls_resp_valid, ls_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/ysyx_22050612_mem_arb.sv
// Purpose: two-master (IFU, LSU) to one data-memory port arbiter, one transaction in flight.
// Latency: grant at N, mem_req_valid at N+1, owner's resp_valid in the same cycle as mem_resp_valid.
// Backpressure: grants only in IDLE; request held stable while mem_req_ready is low.
module ysyx_22050612_mem_arb #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ysyx_22050612_mem_arb_if.slave    bus,
  output logic                      busy,
  output logic                      err_resp
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // captured request, replayed on the memory port until accepted
  typedef struct packed {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } req_t;

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  req_t              req_q, req_d;
  logic              cap_en;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic              err_q;

  logic              if_win, ls_win;
  logic              if_req_ready, ls_req_ready;
  logic              mem_req_valid;
  logic              resp_fire;
  logic              if_resp_valid, ls_resp_valid;

  // Arbitration: LSU has priority unless the IFU has waited long enough.
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (state_q == S_IDLE) begin
      if_win = bus.if_req_valid && ((wait_cnt_q >= WAIT_LIM) || !bus.ls_req_valid);
      ls_win = bus.ls_req_valid && !if_win;
    end
  end

  // Next-state, capture selection and handshake outputs.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    req_d         = req_q;
    cap_en        = 1'b0;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    resp_fire     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (if_win) begin
          if_req_ready = 1'b1;
          cap_en       = 1'b1;
          owner_d      = OWN_IF;
          // fetches are always plain reads
          req_d.addr   = bus.if_addr;
          req_d.wen    = 1'b0;
          req_d.wdata  = '0;
          req_d.wmask  = '0;
          state_d      = S_REQ;
        end else if (ls_win) begin
          ls_req_ready = 1'b1;
          cap_en       = 1'b1;
          owner_d      = OWN_LS;
          req_d.addr   = bus.ls_addr;
          req_d.wen    = bus.ls_wen;
          req_d.wdata  = bus.ls_wdata;
          req_d.wmask  = bus.ls_wmask;
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (bus.mem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_resp_valid) begin
          resp_fire = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Owner and request capture, written only on a grant so mem_* hold afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= OWN_IF;
      req_q   <= '0;
    end else if (cap_en) begin
      owner_q <= owner_d;
      req_q   <= req_d;
    end
  end

  // IFU wait counter: counts pending-but-not-accepted cycles, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (!bus.if_req_valid || if_req_ready) begin
      wait_cnt_q <= '0;
    end else if (wait_cnt_q != {CNT_W{1'b1}}) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  // Sticky flag for a memory response that arrives with nothing outstanding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (bus.mem_resp_valid && (state_q != S_WAIT)) begin
      err_q <= 1'b1;
    end
  end

  // Route the response to the owner; read data is zero except while a pulse is live.
  always_comb begin
    if_resp_valid = resp_fire && (owner_q == OWN_IF);
    ls_resp_valid = resp_fire && (owner_q == OWN_LS);
  end

  assign bus.if_req_ready  = if_req_ready;
  assign bus.ls_req_ready  = ls_req_ready;
  assign bus.if_resp_valid = if_resp_valid;
  assign bus.ls_resp_valid = ls_resp_valid;
  assign bus.if_rdata      = if_resp_valid ? bus.mem_rdata : '0;
  assign bus.ls_rdata      = ls_resp_valid ? bus.mem_rdata : '0;

  assign bus.mem_req_valid = mem_req_valid;
  assign bus.mem_addr      = req_q.addr;
  assign bus.mem_wen       = req_q.wen;
  assign bus.mem_wdata     = req_q.wdata;
  assign bus.mem_wmask     = req_q.wmask;

  assign busy     = (state_q != S_IDLE);
  assign err_resp = err_q;

endmodule

// File: tb/tb_ysyx_22050612_mem_arb.sv
// Purpose: directed and randomized checks of the memory arbiter against a transaction-level model.
// Latency: sampled on the falling edge, model advanced on the rising edge.
// Backpressure: memory ready/response driven by the bench, including held-off acceptance.
module tb_ysyx_22050612_mem_arb;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 8;
  localparam int SAT      = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic busy, err_resp;

  always #5 clk = ~clk;

  ysyx_22050612_mem_arb_if bus ();

  ysyx_22050612_mem_arb #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .err_resp (err_resp)
  );

  int checks = 0;
  int errors = 0;

  // reference model: one outstanding transaction, described by "in flight" and "sent"
  bit          m_known = 1'b0;
  bit          m_busy, m_sent, m_own_if, m_err, m_wd_ok;
  logic [63:0] m_addr, m_wdata;
  logic        m_wen;
  logic [7:0]  m_wmask;
  int          m_wait;
  bit          e_if_rdy, e_ls_rdy, e_resp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Falling edge: predict combinational outputs and compare.
  task automatic sample();
    @(negedge clk);
    e_if_rdy = !m_busy && bus.if_req_valid && (m_wait >= MAX_WAIT || !bus.ls_req_valid);
    e_ls_rdy = !m_busy && bus.ls_req_valid && !e_if_rdy;
    e_resp   = m_busy && m_sent && bus.mem_resp_valid;
    if (m_known) begin
      chk("if_req_ready", bus.if_req_ready, e_if_rdy);
      chk("ls_req_ready", bus.ls_req_ready, e_ls_rdy);
      chk("mem_req_valid", bus.mem_req_valid, m_busy && !m_sent);
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_wen", bus.mem_wen, m_wen);
      chk("mem_wmask", bus.mem_wmask, m_wmask);
      if (m_wd_ok) chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("if_resp_valid", bus.if_resp_valid, e_resp && m_own_if);
      chk("ls_resp_valid", bus.ls_resp_valid, e_resp && !m_own_if);
      if (e_resp && m_own_if) chk("if_rdata", bus.if_rdata, bus.mem_rdata);
      if (e_resp && !m_own_if && !m_wen) chk("ls_rdata", bus.ls_rdata, bus.mem_rdata);
      chk("busy", busy, m_busy);
      chk("err_resp", err_resp, m_err);
    end
  endtask

  // Rising edge: apply the rules to the model, then step off the edge.
  task automatic advance();
    @(posedge clk);
    if (!rst_n) begin
      m_known = 1'b1; m_busy = 0; m_sent = 0; m_own_if = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_wen = 0; m_wmask = '0; m_wd_ok = 1; m_wait = 0;
    end else if (m_known) begin
      if (bus.mem_resp_valid && !(m_busy && m_sent)) m_err = 1'b1;
      if (bus.if_req_valid && !e_if_rdy) m_wait = (m_wait < SAT) ? m_wait + 1 : SAT;
      else m_wait = 0;
      if (!m_busy) begin
        if (e_if_rdy) begin
          m_busy = 1; m_sent = 0; m_own_if = 1;
          m_addr = bus.if_addr; m_wen = 0; m_wmask = '0; m_wd_ok = 0;
        end else if (e_ls_rdy) begin
          m_busy = 1; m_sent = 0; m_own_if = 0;
          m_addr = bus.ls_addr; m_wen = bus.ls_wen; m_wmask = bus.ls_wmask;
          m_wdata = bus.ls_wdata; m_wd_ok = 1;
        end
      end else if (!m_sent) begin
        if (bus.mem_req_ready) m_sent = 1;
      end else if (bus.mem_resp_valid) begin
        m_busy = 0;
      end
    end
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  // Cooperative memory: accepts at once, answers the cycle after acceptance.
  task automatic auto_mem();
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = m_busy && m_sent;
    bus.mem_rdata      = {$urandom, $urandom};
  endtask

  task automatic new_ls();
    bus.ls_addr  = {$urandom, $urandom};
    bus.ls_wen   = $urandom_range(0, 1);
    bus.ls_wdata = {$urandom, $urandom};
    bus.ls_wmask = 8'($urandom);
  endtask

  task automatic drain();
    bus.if_req_valid = 0;
    bus.ls_req_valid = 0;
    for (int i = 0; i < 30 && m_busy; i++) begin
      auto_mem();
      cycle();
    end
    bus.mem_resp_valid = 0;
    sample();
    chk("drain_idle", busy, 1'b0);
    advance();
  endtask

  task automatic do_reset();
    rst_n = 0;
    bus.mem_resp_valid = 0;
    cycle();
    rst_n = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int arb, got_arb, tx;
    bit got;
    rst_n = 0;
    bus.if_req_valid = 0; bus.if_addr = '0;
    bus.ls_req_valid = 0; bus.ls_addr = '0; bus.ls_wen = 0; bus.ls_wdata = '0; bus.ls_wmask = '0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_rdata = '0;
    cycle();
    cycle();
    rst_n = 1;

    // reset state, with live data on mem_rdata that must not leak through
    bus.mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    sample();
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_resp, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 64'h0);
    chk("rst_if_rdata", bus.if_rdata, 64'h0);
    chk("rst_ls_rdata", bus.ls_rdata, 64'h0);
    advance();

    // IFU only, minimum latency
    bus.if_req_valid = 1; bus.if_addr = 64'h8000_0000; bus.mem_req_ready = 1;
    sample(); chk("t1_if_ready_c0", bus.if_req_ready, 1'b1); advance();
    bus.if_req_valid = 0;
    sample();
    chk("t1_mreq_c1", bus.mem_req_valid, 1'b1);
    chk("t1_maddr_c1", bus.mem_addr, 64'h8000_0000);
    chk("t1_mwen_c1", bus.mem_wen, 1'b0);
    advance();
    bus.mem_resp_valid = 1; bus.mem_rdata = 64'h0000_0013_0000_0093;
    sample();
    chk("t1_if_resp_c2", bus.if_resp_valid, 1'b1);
    chk("t1_if_rdata_c2", bus.if_rdata, 64'h0000_0013_0000_0093);
    chk("t1_ls_resp_c2", bus.ls_resp_valid, 1'b0);
    advance();
    bus.mem_resp_valid = 0;

    // contention: LSU store wins the first arbitration
    bus.if_req_valid = 1; bus.if_addr = 64'h8000_0004;
    bus.ls_req_valid = 1; bus.ls_addr = 64'h8000_1004; bus.ls_wen = 1;
    bus.ls_wdata = 64'h1122_3344_0000_0000; bus.ls_wmask = 8'hF0;
    sample();
    chk("t2_ls_ready", bus.ls_req_ready, 1'b1);
    chk("t2_if_ready", bus.if_req_ready, 1'b0);
    advance();
    sample();
    chk("t2_mwen", bus.mem_wen, 1'b1);
    chk("t2_mwmask", bus.mem_wmask, 64'hF0);
    chk("t2_mwdata", bus.mem_wdata, 64'h1122_3344_0000_0000);
    advance();
    bus.mem_resp_valid = 1;
    sample(); chk("t2_ls_ack", bus.ls_resp_valid, 1'b1); advance();
    bus.ls_req_valid = 0;
    drain();

    // starvation: both valid forever, IFU must win within MAX_WAIT+1 arbitrations
    bus.if_req_valid = 1; bus.ls_req_valid = 1; new_ls();
    arb = 0; got = 0; got_arb = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      auto_mem();
      sample();
      if (!m_busy) arb++;
      if (bus.if_req_ready === 1'b1) begin got = 1; got_arb = arb; end
      advance();
      if (e_ls_rdy) new_ls();
    end
    chk("t3_ifu_granted", got, 1'b1);
    chk("t3_grant_by_5th", (got_arb >= 1 && got_arb <= MAX_WAIT + 1), 1'b1);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      auto_mem();
      sample();
      if (!m_busy) begin
        got = 1;
        chk("t3_cnt_cleared_ls_wins", bus.ls_req_ready, 1'b1);
      end
      advance();
    end
    chk("t3_next_arb_seen", got, 1'b1);
    drain();

    // backpressure: memory refuses for 6 cycles
    bus.if_req_valid = 1; bus.if_addr = 64'h0000_0000_1234_5678; bus.mem_req_ready = 0;
    cycle();
    bus.if_req_valid = 0; bus.ls_req_valid = 1; new_ls();
    for (int i = 0; i < 6; i++) begin
      sample();
      chk("t4_mreq_held", bus.mem_req_valid, 1'b1);
      chk("t4_maddr_held", bus.mem_addr, 64'h0000_0000_1234_5678);
      chk("t4_no_grant", bus.ls_req_ready, 1'b0);
      chk("t4_busy", busy, 1'b1);
      advance();
    end
    bus.mem_req_ready = 1;
    cycle();
    bus.ls_req_valid = 0; bus.mem_resp_valid = 1;
    sample(); chk("t4_if_resp", bus.if_resp_valid, 1'b1); advance();
    drain();

    // reset in WAIT, then a stale response
    bus.if_req_valid = 1; bus.if_addr = 64'h8000_0040; bus.mem_req_ready = 1;
    cycle();
    bus.if_req_valid = 0;
    cycle();
    rst_n = 0; bus.mem_resp_valid = 0;
    cycle();
    rst_n = 1; bus.mem_resp_valid = 1; bus.mem_rdata = 64'hA5A5_A5A5_5A5A_5A5A;
    sample();
    chk("t5_if_resp", bus.if_resp_valid, 1'b0);
    chk("t5_ls_resp", bus.ls_resp_valid, 1'b0);
    chk("t5_if_rdata", bus.if_rdata, 64'h0);
    chk("t5_ls_rdata", bus.ls_rdata, 64'h0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_mreq", bus.mem_req_valid, 1'b0);
    chk("t5_maddr", bus.mem_addr, 64'h0);
    chk("t5_mwdata", bus.mem_wdata, 64'h0);
    advance();
    bus.mem_resp_valid = 0;
    sample(); chk("t5_err_set", err_resp, 1'b1); advance();

    // spurious response in IDLE, then 10 normal transactions
    do_reset();
    bus.mem_resp_valid = 1;
    sample(); chk("t6_err_before", err_resp, 1'b0); advance();
    bus.mem_resp_valid = 0;
    for (tx = 0; tx < 10; tx++) begin
      if (tx % 2 == 0) begin bus.if_req_valid = 1; bus.if_addr = {$urandom, $urandom}; end
      else begin bus.ls_req_valid = 1; new_ls(); end
      bus.mem_req_ready = 1;
      cycle();
      bus.if_req_valid = 0; bus.ls_req_valid = 0;
      drain();
      chk("t6_err_sticky", err_resp, 1'b1);
    end
    do_reset();
    sample(); chk("t6_err_cleared", err_resp, 1'b0); advance();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (!bus.if_req_valid || e_if_rdy) begin
        bus.if_req_valid = ($urandom_range(0, 2) != 0);
        bus.if_addr = {$urandom, $urandom};
      end else if ($urandom_range(0, 7) == 0) begin
        bus.if_req_valid = 0;
      end
      if (!bus.ls_req_valid || e_ls_rdy) begin
        bus.ls_req_valid = ($urandom_range(0, 2) != 0);
        new_ls();
      end else if ($urandom_range(0, 7) == 0) begin
        bus.ls_req_valid = 0;
      end
      bus.mem_req_ready  = $urandom_range(0, 1);
      bus.mem_resp_valid = (m_busy && m_sent) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.mem_rdata      = {$urandom, $urandom};
      cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
